// File: rtl/misr_if.sv
// Stimulus/result bundle between a BIST controller (master) and the MISR (slave).
interface misr_if #(
    parameter int unsigned WIDTH = 3
);
    logic             start;
    logic [WIDTH:1]   din;
    logic             din_valid;
    logic [WIDTH:1]   sig;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;

    modport master (
        output start, din, din_valid,
        input  sig, busy, done, pass, timeout
    );

    modport slave (
        input  start, din, din_valid,
        output sig, busy, done, pass, timeout
    );
endinterface

// File: rtl/misr_signature_analyzer.sv
// Galois MISR with IDLE/RUN/DONE control; compacts PATTERN_COUNT words and checks vs GOLDEN.
// Optional idle-cycle watchdog enabled by defining MISR_TIMEOUT_EN.
module misr_signature_analyzer #(
    parameter int unsigned    WIDTH         = 3,
    parameter logic [WIDTH:1] TAPS          = 3'b011,
    parameter logic [WIDTH:1] SEED          = 3'b000,
    parameter int unsigned    PATTERN_COUNT = 7,
    parameter logic [WIDTH:1] GOLDEN        = 3'b111,
    parameter int unsigned    TIMEOUT       = 15
) (
    input logic  clk,
    input logic  clr,
    misr_if.slave bus
);
    localparam int unsigned         CntW    = $clog2(PATTERN_COUNT + 1);
    localparam logic [CntW-1:0]     CntLast = CntW'(PATTERN_COUNT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [WIDTH:1]  sig_q, sig_d, sig_step;
    logic [CntW-1:0] count_q, count_d;
    logic            pass_q, pass_d;

    // Shift toward MSB, fold the outgoing MSB back through the tap mask, then mix in data.
    assign sig_step = {sig_q[WIDTH-1:1], 1'b0} ^ (sig_q[WIDTH] ? TAPS : '0) ^ bus.din;

`ifdef MISR_TIMEOUT_EN
    localparam int unsigned         IdleW    = $clog2(TIMEOUT + 1);
    localparam logic [IdleW-1:0]    IdleLast = IdleW'(TIMEOUT - 1);

    logic [IdleW-1:0] idle_q, idle_d;
    logic             timeout_q, timeout_d;

    assign bus.timeout = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign bus.timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= StIdle;
            sig_q     <= SEED;
            count_q   <= '0;
            pass_q    <= 1'b0;
`ifdef MISR_TIMEOUT_EN
            idle_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sig_q     <= sig_d;
            count_q   <= count_d;
            pass_q    <= pass_d;
`ifdef MISR_TIMEOUT_EN
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        sig_d     = sig_q;
        count_d   = count_q;
        pass_d    = pass_q;
`ifdef MISR_TIMEOUT_EN
        idle_d    = idle_q;
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d   = StRun;
                    sig_d     = SEED;
                    count_d   = '0;
                    pass_d    = 1'b0;
`ifdef MISR_TIMEOUT_EN
                    idle_d    = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            StRun: begin
                if (bus.din_valid) begin
                    sig_d   = sig_step;
                    count_d = count_q + CntW'(1);
`ifdef MISR_TIMEOUT_EN
                    idle_d  = '0;
`endif
                    if (count_q == CntLast) begin
                        state_d = StDone;
                        pass_d  = (sig_step == GOLDEN);
                    end
                end
`ifdef MISR_TIMEOUT_EN
                else begin
                    idle_d = idle_q + IdleW'(1);
                    if (idle_q == IdleLast) begin
                        state_d   = StDone;
                        pass_d    = 1'b0;
                        timeout_d = 1'b1;
                    end
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.sig  = sig_q;
    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.pass = pass_q;
endmodule

// File: tb/tb_misr_signature_analyzer.sv
// Bench for misr_signature_analyzer: three DUT configurations, scoreboard of expected signatures.
// Timeout checks follow MISR_TIMEOUT_EN when the bench is built with the macro.
module tb_misr_signature_analyzer;
    logic clk = 1'b0;
    logic clr;
    logic start_v, valid_v;
    logic [3:1] din_v;
    int unsigned sel;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:1] exp_q[$];

    always #5 clk = ~clk;

    misr_if #(.WIDTH(3)) if_a ();
    misr_if #(.WIDTH(3)) if_b ();
    misr_if #(.WIDTH(3)) if_c ();

    assign if_a.start = start_v & (sel == 0);
    assign if_b.start = start_v & (sel == 1);
    assign if_c.start = start_v & (sel == 2);
    assign if_a.din_valid = valid_v & (sel == 0);
    assign if_b.din_valid = valid_v & (sel == 1);
    assign if_c.din_valid = valid_v & (sel == 2);
    assign if_a.din = din_v;
    assign if_b.din = din_v;
    assign if_c.din = din_v;

    misr_signature_analyzer #(.GOLDEN(3'b010), .PATTERN_COUNT(4)) u_a (
        .clk(clk), .clr(clr), .bus(if_a.slave));
    misr_signature_analyzer #(.PATTERN_COUNT(4)) u_b (
        .clk(clk), .clr(clr), .bus(if_b.slave));
    misr_signature_analyzer #(.GOLDEN(3'b101), .PATTERN_COUNT(1)) u_c (
        .clk(clk), .clr(clr), .bus(if_c.slave));

    logic [3:1] o_sig;
    logic o_busy, o_done, o_pass, o_tmo;
    assign o_sig  = (sel == 0) ? if_a.sig  : (sel == 1) ? if_b.sig  : if_c.sig;
    assign o_busy = (sel == 0) ? if_a.busy : (sel == 1) ? if_b.busy : if_c.busy;
    assign o_done = (sel == 0) ? if_a.done : (sel == 1) ? if_b.done : if_c.done;
    assign o_pass = (sel == 0) ? if_a.pass : (sel == 1) ? if_b.pass : if_c.pass;
    assign o_tmo  = (sel == 0) ? if_a.timeout : (sel == 1) ? if_b.timeout : if_c.timeout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        check("start_busy", o_busy, 1);
        check("start_sig", o_sig, 3'b000);
        check("start_done", o_done, 0);
    endtask

    // Push the required signature, present the word, then pop and compare after the edge.
    task automatic send_word(input logic [3:1] d, input logic [3:1] exp);
        logic [3:1] e;
        exp_q.push_back(exp);
        din_v   = d;
        valid_v = 1'b1;
        tick();
        valid_v = 1'b0;
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("word_sig", o_sig, e);
        end
    endtask

    task automatic gen_run(input logic [3:1] w2, input logic [3:1] e2, input logic [3:1] e3);
        logic [3:1] words [4];
        logic [3:1] exps  [4];
        int gaps [4];
        words = '{3'b001, 3'b011, w2, 3'b110};
        exps  = '{3'b001, 3'b001, e2, e3};
        gaps  = '{2, 0, 3, 1};
        do_start();
        for (int i = 0; i < 4; i++) begin
            send_word(words[i], exps[i]);
            if (i < 3) begin
                for (int g = 0; g < gaps[i]; g++) begin
                    tick();
                    check("gap_hold", o_sig, exps[i]);
                end
            end
        end
        check("gen_done", o_done, 1);
    endtask

    initial begin
        clr = 1'b1; start_v = 1'b0; valid_v = 1'b0; din_v = '0; sel = 0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #0;
            check("rst_sig", o_sig, 3'b000);
            check("rst_busy", o_busy, 0);
            check("rst_done", o_done, 0);
            check("rst_pass", o_pass, 0);
            check("rst_tmo", o_tmo, 0);
        end
        clr = 1'b0;
        sel = 0;
        tick();
        tick();
        check("idle_sig", o_sig, 3'b000);
        check("idle_busy", o_busy, 0);

        // Passing run with GOLDEN=010
        do_start();
        send_word(3'b001, 3'b001);
        send_word(3'b010, 3'b000);
        send_word(3'b011, 3'b011);
        check("a_busy_pre", o_busy, 1);
        send_word(3'b100, 3'b010);
        check("a_done", o_done, 1);
        check("a_pass", o_pass, 1);
        check("a_busy", o_busy, 0);
        send_word(3'b111, 3'b010);
        check("a_done_hold", o_done, 1);
        do_start();
        check("a_restart_pass", o_pass, 0);
        send_word(3'b001, 3'b001);
        send_word(3'b010, 3'b000);
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        check("a_midstart_sig", o_sig, 3'b000);
        check("a_midstart_busy", o_busy, 1);
        send_word(3'b011, 3'b011);
        send_word(3'b100, 3'b010);
        check("a_done2", o_done, 1);
        check("a_pass2", o_pass, 1);

        // Generator stream on defaults
        sel = 1;
        #0;
        din_v = 3'b111;
        start_v = 1'b1;
        valid_v = 1'b1;
        tick();
        start_v = 1'b0;
        valid_v = 1'b0;
        check("b_startvalid_sig", o_sig, 3'b000);
        check("b_startvalid_busy", o_busy, 1);
        send_word(3'b001, 3'b001);
        send_word(3'b011, 3'b001);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("b_midclr_busy", o_busy, 0);
        check("b_midclr_sig", o_sig, 3'b000);
        gen_run(3'b111, 3'b101, 3'b111);
        check("b_pass", o_pass, 1);
        gen_run(3'b101, 3'b111, 3'b011);
        check("b_bad_pass", o_pass, 0);
        check("b_bad_sig", o_sig, 3'b011);
        clr = 1'b1;
        start_v = 1'b1;
        tick();
        clr = 1'b0;
        start_v = 1'b0;
        check("b_clrstart_busy", o_busy, 0);
        check("b_clrstart_done", o_done, 0);

        // Idle-limit behaviour
        do_start();
        send_word(3'b001, 3'b001);
        for (int i = 0; i < 14; i++) tick();
        check("t_busy14", o_busy, 1);
        tick();
`ifdef MISR_TIMEOUT_EN
        check("t_done", o_done, 1);
        check("t_tmo", o_tmo, 1);
        check("t_pass", o_pass, 0);
        do_start();
        check("t_tmo_clear", o_tmo, 0);
`else
        check("t_busy15", o_busy, 1);
        check("t_tmo", o_tmo, 0);
        check("t_sig_hold", o_sig, 3'b001);
`endif

        // PATTERN_COUNT=1
        sel = 2;
        #0;
        do_start();
        send_word(3'b101, 3'b101);
        check("c_done", o_done, 1);
        check("c_pass", o_pass, 1);

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
